// File: rtl/axis_to_nseg_packer.sv
// AXI4-Stream to N-segment segmented-stream packer: one ingress beat becomes one egress word
// of NUM_SEG segments with per-segment ena/sop/eop/err/mty, buffered in a small egress FIFO.
module axis_to_nseg_packer #(
  parameter int NUM_SEG    = 2,
  parameter int SEG_DW     = 128,
  parameter int MTY_W      = 4,
  parameter int TID_WIDTH  = 6,
  parameter int EGR_TID_W  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                              aclk,
  input  logic                              arstn,
  output logic                              axis_s_tready,
  input  logic                              axis_s_tvalid,
  input  logic [NUM_SEG*SEG_DW-1:0]         axis_s_tdata,
  input  logic [NUM_SEG*(SEG_DW/8)-1:0]     axis_s_tkeep,
  input  logic                              axis_s_tlast,
  input  logic [TID_WIDTH-1:0]              axis_s_tid,
  input  logic                              axiseg_ready,
  output logic                              axiseg_valid,
  output logic [EGR_TID_W-1:0]              axiseg_tid,
  output logic [NUM_SEG*SEG_DW-1:0]         axiseg_tdata,
  output logic [NUM_SEG-1:0]                axiseg_tuser_ena,
  output logic [NUM_SEG-1:0]                axiseg_tuser_sop,
  output logic [NUM_SEG-1:0]                axiseg_tuser_eop,
  output logic [NUM_SEG-1:0]                axiseg_tuser_err,
  output logic [NUM_SEG*MTY_W-1:0]          axiseg_tuser_mty,
  input  logic                              err_clr,
  output logic                              err_alignment,
  output logic [CNT_W-1:0]                  pkt_cnt
);

  localparam int SEG_BY = SEG_DW / 8;
  localparam int DW     = NUM_SEG * SEG_DW;
  localparam int KW     = NUM_SEG * SEG_BY;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_SOP_WAIT = 1'b0;
  localparam logic [0:0] ST_IN_PKT   = 1'b1;

  function automatic logic [MTY_W-1:0] empty_bytes(input logic [SEG_BY-1:0] keep);
    int ones;
    ones = 0;
    for (int i = 0; i < SEG_BY; i++) ones += int'(keep[i]);
    return MTY_W'(SEG_BY - ones);
  endfunction

  logic [0:0]           state_q, state_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic                 rdy_en_q, rdy_en_d;

  logic [DW-1:0]            mem_data [FIFO_DEPTH];
  logic [NUM_SEG-1:0]       mem_ena  [FIFO_DEPTH];
  logic [NUM_SEG-1:0]       mem_sop  [FIFO_DEPTH];
  logic [NUM_SEG-1:0]       mem_eop  [FIFO_DEPTH];
  logic [NUM_SEG-1:0]       mem_err  [FIFO_DEPTH];
  logic [NUM_SEG*MTY_W-1:0] mem_mty  [FIFO_DEPTH];
  logic [EGR_TID_W-1:0]     mem_tid  [FIFO_DEPTH];

  logic [NUM_SEG-1:0]       b_ena, b_sop, b_eop, b_err, lo_mask, hi_mask;
  logic [NUM_SEG*MTY_W-1:0] b_mty;
  logic [EGR_TID_W-1:0]     b_tid;
  logic                     keep_zero, keep_full, keep_gap, beat_err;
  logic                     push, pop, fifo_valid;
  int                       eop_ones;

  assign fifo_valid    = (count_q != '0);
  assign axis_s_tready = rdy_en_q && (count_q < DEPTH_C);
  assign push          = axis_s_tvalid && axis_s_tready;
  assign pop           = fifo_valid && axiseg_ready;

  // Per-beat segment flags; a gap anywhere in keep (a 1 above a 0) counts as misalignment.
  always_comb begin
    b_ena     = '0;
    b_sop     = '0;
    b_eop     = '0;
    b_err     = '0;
    b_mty     = '0;
    lo_mask   = '0;
    hi_mask   = '0;
    keep_gap  = 1'b0;
    keep_zero = ~|axis_s_tkeep;
    keep_full = &axis_s_tkeep;
    for (int k = 0; k < NUM_SEG; k++) b_ena[k] = |axis_s_tkeep[k*SEG_BY +: SEG_BY];
    for (int i = 1; i < KW; i++)
      if (axis_s_tkeep[i] && !axis_s_tkeep[i-1]) keep_gap = 1'b1;
    for (int k = 0; k < NUM_SEG; k++)
      if (b_ena[k]) begin
        hi_mask    = '0;
        hi_mask[k] = 1'b1;
      end
    for (int k = NUM_SEG - 1; k >= 0; k--)
      if (b_ena[k]) begin
        lo_mask    = '0;
        lo_mask[k] = 1'b1;
      end
    beat_err = (!axis_s_tlast && !keep_full) || keep_gap ||
               ((state_q == ST_IN_PKT) && (axis_s_tid != tid_q)) ||
               (axis_s_tlast && keep_zero);
    if (axis_s_tlast && keep_zero) begin
      // An empty end-of-packet beat still has to close the packet, so it is forced onto segment 0.
      b_ena = NUM_SEG'(1);
      b_eop = NUM_SEG'(1);
      b_err = NUM_SEG'(1);
      if (state_q == ST_SOP_WAIT) b_sop = NUM_SEG'(1);
      b_mty[MTY_W-1:0] = MTY_W'(SEG_BY - 1);
    end else begin
      if (state_q == ST_SOP_WAIT) b_sop = lo_mask;
      if (axis_s_tlast) b_eop = hi_mask;
      if (beat_err) b_err = hi_mask;
      for (int k = 0; k < NUM_SEG; k++)
        if (axis_s_tlast && hi_mask[k])
          b_mty[k*MTY_W +: MTY_W] = empty_bytes(axis_s_tkeep[k*SEG_BY +: SEG_BY]);
    end
  end

  assign b_tid = (state_q == ST_SOP_WAIT) ? axis_s_tid[EGR_TID_W-1:0] : tid_q[EGR_TID_W-1:0];

  always_comb begin
    eop_ones = 0;
    for (int k = 0; k < NUM_SEG; k++) eop_ones += int'(mem_eop[rd_ptr_q][k]);
  end

  always_comb begin
    state_d   = state_q;
    tid_d     = tid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    pkt_cnt_d = pkt_cnt_q;
    rdy_en_d  = 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      state_d  = axis_s_tlast ? ST_SOP_WAIT : ST_IN_PKT;
      if (state_q == ST_SOP_WAIT) tid_d = axis_s_tid;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pkt_cnt_d = pkt_cnt_q + CNT_W'(eop_ones);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push && beat_err) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= ST_SOP_WAIT;
      tid_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  // Storage needs no reset: entries are only visible through a non-empty count.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= axis_s_tdata;
      mem_ena[wr_ptr_q]  <= b_ena;
      mem_sop[wr_ptr_q]  <= b_sop;
      mem_eop[wr_ptr_q]  <= b_eop;
      mem_err[wr_ptr_q]  <= b_err;
      mem_mty[wr_ptr_q]  <= b_mty;
      mem_tid[wr_ptr_q]  <= b_tid;
    end
  end

  assign axiseg_valid     = fifo_valid;
  assign axiseg_tdata     = fifo_valid ? mem_data[rd_ptr_q] : '0;
  assign axiseg_tuser_ena = fifo_valid ? mem_ena[rd_ptr_q]  : '0;
  assign axiseg_tuser_sop = fifo_valid ? mem_sop[rd_ptr_q]  : '0;
  assign axiseg_tuser_eop = fifo_valid ? mem_eop[rd_ptr_q]  : '0;
  assign axiseg_tuser_err = fifo_valid ? mem_err[rd_ptr_q]  : '0;
  assign axiseg_tuser_mty = fifo_valid ? mem_mty[rd_ptr_q]  : '0;
  assign axiseg_tid       = fifo_valid ? mem_tid[rd_ptr_q]  : '0;
  assign err_alignment    = err_q;
  assign pkt_cnt          = pkt_cnt_q;

endmodule

// File: tb/tb_axis_to_nseg_packer.sv
// Directed bench for axis_to_nseg_packer with default parameters (2 x 128-bit segments, depth 4).
module tb_axis_to_nseg_packer;

  localparam int DW = 256;
  localparam int KW = 32;

  logic           aclk;
  logic           arstn;
  logic           axis_s_tready;
  logic           axis_s_tvalid;
  logic [DW-1:0]  axis_s_tdata;
  logic [KW-1:0]  axis_s_tkeep;
  logic           axis_s_tlast;
  logic [5:0]     axis_s_tid;
  logic           axiseg_ready;
  logic           axiseg_valid;
  logic [2:0]     axiseg_tid;
  logic [DW-1:0]  axiseg_tdata;
  logic [1:0]     axiseg_tuser_ena;
  logic [1:0]     axiseg_tuser_sop;
  logic [1:0]     axiseg_tuser_eop;
  logic [1:0]     axiseg_tuser_err;
  logic [7:0]     axiseg_tuser_mty;
  logic           err_clr;
  logic           err_alignment;
  logic [31:0]    pkt_cnt;

  int errors = 0;
  int checks = 0;
  logic [19:0] obs;

  axis_to_nseg_packer dut (
    .aclk             (aclk),
    .arstn            (arstn),
    .axis_s_tready    (axis_s_tready),
    .axis_s_tvalid    (axis_s_tvalid),
    .axis_s_tdata     (axis_s_tdata),
    .axis_s_tkeep     (axis_s_tkeep),
    .axis_s_tlast     (axis_s_tlast),
    .axis_s_tid       (axis_s_tid),
    .axiseg_ready     (axiseg_ready),
    .axiseg_valid     (axiseg_valid),
    .axiseg_tid       (axiseg_tid),
    .axiseg_tdata     (axiseg_tdata),
    .axiseg_tuser_ena (axiseg_tuser_ena),
    .axiseg_tuser_sop (axiseg_tuser_sop),
    .axiseg_tuser_eop (axiseg_tuser_eop),
    .axiseg_tuser_err (axiseg_tuser_err),
    .axiseg_tuser_mty (axiseg_tuser_mty),
    .err_clr          (err_clr),
    .err_alignment    (err_alignment),
    .pkt_cnt          (pkt_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  assign obs = {axiseg_valid, axiseg_tuser_ena, axiseg_tuser_sop, axiseg_tuser_eop,
                axiseg_tuser_err, axiseg_tuser_mty, axiseg_tid};

  function automatic logic [19:0] mk(input logic v, input logic [1:0] ena, input logic [1:0] sop,
                                     input logic [1:0] eop, input logic [1:0] err,
                                     input logic [7:0] mty, input logic [2:0] tid);
    return {v, ena, sop, eop, err, mty, tid};
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 ^ 32'(i);
    return {8{w}};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [5:0] id);
    int cyc;
    axis_s_tdata  = d;
    axis_s_tkeep  = k;
    axis_s_tlast  = l;
    axis_s_tid    = id;
    axis_s_tvalid = 1'b1;
    cyc = 0;
    while (axis_s_tready !== 1'b1 && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    checks++;
    if (axis_s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_timeout: tready=%b required 1", axis_s_tready);
    end
    @(negedge aclk);
    axis_s_tvalid = 1'b0;
  endtask

  task automatic pop_word();
    axiseg_ready = 1'b1;
    @(negedge aclk);
    axiseg_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (axis_s_tready !== 1'b0 || obs !== 20'h0 || axiseg_tdata !== '0 || pkt_cnt !== 32'd0 ||
        err_alignment !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: tready=%b obs=%h data_nz=%b cnt=%0d err=%b required all 0",
               axis_s_tready, obs, |axiseg_tdata, pkt_cnt, err_alignment);
    end
    @(negedge aclk);
    @(negedge aclk);
    arstn = 1'b1;
    @(negedge aclk);
    checks++;
    if (axis_s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tready_after: got %b required 1", axis_s_tready);
    end
  endtask

  task automatic test_basic_packet();
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("[TB] FAIL t1_idle: got %h required 0", obs);
    end
    send_beat(pat(0), '1, 1'b0, 6'd1);
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 3'd1)) begin
      errors++;
      $display("[TB] FAIL t1_w0: got %h required %h", obs, mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 3'd1));
    end
    send_beat(pat(1), '1, 1'b0, 6'd1);
    send_beat(pat(2), 32'h0000_00FF, 1'b1, 6'd1);
    pop_word();
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 3'd1) || axiseg_tdata !== pat(1)) begin
      errors++;
      $display("[TB] FAIL t1_w1: got %h required %h (data ok=%b)", obs,
               mk(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 3'd1), axiseg_tdata === pat(1));
    end
    pop_word();
    checks++;
    if (obs !== mk(1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 8'h08, 3'd1) || axiseg_tdata !== pat(2)) begin
      errors++;
      $display("[TB] FAIL t1_w2: got %h required %h (data ok=%b)", obs,
               mk(1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 8'h08, 3'd1), axiseg_tdata === pat(2));
    end
    checks++;
    if (pkt_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL t1_cnt_before: got %0d required 0", pkt_cnt);
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd1 || axiseg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_cnt_after: cnt=%0d valid=%b required 1 and 0", pkt_cnt, axiseg_valid);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send_beat(pat(10 + i), '1, 1'b0, 6'd2);
    checks++;
    if (axis_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t2_full: tready=%b required 0", axis_s_tready);
    end
    axis_s_tdata  = pat(14);
    axis_s_tkeep  = '1;
    axis_s_tlast  = 1'b1;
    axis_s_tid    = 6'd2;
    axis_s_tvalid = 1'b1;
    @(negedge aclk);
    checks++;
    if (axis_s_tready !== 1'b0 || axiseg_tdata !== pat(10)) begin
      errors++;
      $display("[TB] FAIL t2_hold: tready=%b head_ok=%b required 0 and 1", axis_s_tready,
               axiseg_tdata === pat(10));
    end
    axiseg_ready = 1'b1;
    @(negedge aclk);
    axiseg_ready = 1'b0;
    @(negedge aclk);
    axis_s_tvalid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (axiseg_valid !== 1'b1 || axiseg_tdata !== pat(10 + i)) begin
        errors++;
        $display("[TB] FAIL t2_order: word %0d valid=%b data=%h required %h", i, axiseg_valid,
                 axiseg_tdata[31:0], pat(10 + i) & 256'hFFFF_FFFF);
      end
      if (i == 4) begin
        checks++;
        if (obs !== mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b00, 8'h00, 3'd2)) begin
          errors++;
          $display("[TB] FAIL t2_last: got %h required %h", obs, mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b00, 8'h00, 3'd2));
        end
      end
      pop_word();
    end
    checks++;
    if (pkt_cnt !== 32'd2 || axiseg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t2_cnt: cnt=%0d valid=%b required 2 and 0", pkt_cnt, axiseg_valid);
    end
  endtask

  task automatic test_alignment_err();
    send_beat(pat(20), 32'hFFFF_FFFE, 1'b0, 6'd3);
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b10, 8'h00, 3'd3) || err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t3_err_seg1: got %h err=%b required %h err=1", obs, err_alignment,
               mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b10, 8'h00, 3'd3));
    end
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    checks++;
    if (err_alignment !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t3_clear: got %b required 0", err_alignment);
    end
    axis_s_tdata  = pat(21);
    axis_s_tkeep  = 32'hFFFF_0FFF;
    axis_s_tlast  = 1'b1;
    axis_s_tid    = 6'd3;
    axis_s_tvalid = 1'b1;
    err_clr       = 1'b1;
    @(negedge aclk);
    axis_s_tvalid = 1'b0;
    err_clr       = 1'b0;
    checks++;
    if (err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t3_set_over_clr: got %b required 1", err_alignment);
    end
    pop_word();
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'h00, 3'd3)) begin
      errors++;
      $display("[TB] FAIL t3_gap_word: got %h required %h", obs, mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'h00, 3'd3));
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd3) begin
      errors++;
      $display("[TB] FAIL t3_cnt: got %0d required 3", pkt_cnt);
    end
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
  endtask

  task automatic test_tid_change();
    send_beat(pat(30), '1, 1'b0, 6'd5);
    send_beat(pat(31), '1, 1'b1, 6'd6);
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 3'd5)) begin
      errors++;
      $display("[TB] FAIL t4_w0: got %h required %h", obs, mk(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 3'd5));
    end
    pop_word();
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'h00, 3'd5) || err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t4_w1: got %h err=%b required %h err=1", obs, err_alignment,
               mk(1'b1, 2'b11, 2'b00, 2'b10, 2'b10, 8'h00, 3'd5));
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd4) begin
      errors++;
      $display("[TB] FAIL t4_cnt: got %0d required 4", pkt_cnt);
    end
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
  endtask

  task automatic test_empty_keep();
    send_beat(pat(40), '0, 1'b1, 6'd1);
    checks++;
    if (obs !== mk(1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 8'h0F, 3'd1) || err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t5_empty_last: got %h err=%b required %h err=1", obs, err_alignment,
               mk(1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 8'h0F, 3'd1));
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd5) begin
      errors++;
      $display("[TB] FAIL t5_cnt: got %0d required 5", pkt_cnt);
    end
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    send_beat(pat(41), '0, 1'b0, 6'd2);
    checks++;
    if (obs !== mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 3'd2) || axiseg_tdata !== pat(41) ||
        err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t5_empty_mid: got %h err=%b data_ok=%b required %h err=1", obs, err_alignment,
               axiseg_tdata === pat(41), mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 3'd2));
    end
    pop_word();
    send_beat(pat(42), '0, 1'b1, 6'd2);
    checks++;
    if (obs !== mk(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 8'h0F, 3'd2)) begin
      errors++;
      $display("[TB] FAIL t5_empty_close: got %h required %h", obs, mk(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 8'h0F, 3'd2));
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd6) begin
      errors++;
      $display("[TB] FAIL t5_cnt2: got %0d required 6", pkt_cnt);
    end
  endtask

  task automatic test_reset_midpkt();
    send_beat(pat(50), 32'h7FFF_FFFF, 1'b0, 6'd4);
    send_beat(pat(51), '1, 1'b0, 6'd4);
    send_beat(pat(52), '1, 1'b0, 6'd4);
    checks++;
    if (axiseg_valid !== 1'b1 || err_alignment !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_queued: valid=%b err=%b required 1 and 1", axiseg_valid, err_alignment);
    end
    arstn = 1'b0;
    #1;
    checks++;
    if (axiseg_valid !== 1'b0 || pkt_cnt !== 32'd0 || err_alignment !== 1'b0 || axis_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t6_flush: valid=%b cnt=%0d err=%b tready=%b required all 0",
               axiseg_valid, pkt_cnt, err_alignment, axis_s_tready);
    end
    @(negedge aclk);
    arstn = 1'b1;
    @(negedge aclk);
    send_beat(pat(60), '1, 1'b1, 6'd7);
    checks++;
    if (obs !== mk(1'b1, 2'b11, 2'b01, 2'b10, 2'b00, 8'h00, 3'd7) || axiseg_tdata !== pat(60)) begin
      errors++;
      $display("[TB] FAIL t6_new_sop: got %h required %h (data ok=%b)", obs,
               mk(1'b1, 2'b11, 2'b01, 2'b10, 2'b00, 8'h00, 3'd7), axiseg_tdata === pat(60));
    end
    pop_word();
    checks++;
    if (pkt_cnt !== 32'd1 || axiseg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t6_cnt: cnt=%0d valid=%b required 1 and 0", pkt_cnt, axiseg_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arstn         = 1'b0;
    axis_s_tvalid = 1'b0;
    axis_s_tdata  = '0;
    axis_s_tkeep  = '0;
    axis_s_tlast  = 1'b0;
    axis_s_tid    = '0;
    axiseg_ready  = 1'b0;
    err_clr       = 1'b0;
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_alignment_err();
    test_tid_change();
    test_empty_keep();
    test_reset_midpkt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
